// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state encodings, opcodes, mux-select encodings and control word for the multicycle MIPS controller
package mc_ctrl_pkg;
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;
  localparam logic [3:0] S_ILLEGAL = 4'd12;
  localparam logic [3:0] S_BNEEX   = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       instr_done;
    logic       trap;
  } ctrl_t;
endpackage

// File: rtl/mc_ctrl_outdec.sv
// mc_ctrl_outdec: Moore decode of controller state into the datapath control word; MC_BNE_EN adds BNEEX
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] state,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_4;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMMSH;
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord       = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
`ifdef MC_BNE_EN
      S_BNEEX: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
`endif
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JEX: begin
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ILLEGAL: ctrl.trap = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl: multicycle MIPS main control FSM (state register, next state, PCEn, reset gating)
// MC_BNE_EN: when defined, bne decodes to BNEEX (branch on ~Zero); otherwise bne traps as illegal.
module mc_main_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [OPW-1:0] Op,
  input  logic           Zero,
  output logic           IorD,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           RegDst,
  output logic           MemtoReg,
  output logic           RegWrite,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [1:0]     PCSrc,
  output logic           PCEn,
  output logic           InstrDone,
  output logic           Trap
);
  logic [STW-1:0] state, state_nx;
  ctrl_t          c;
  logic           bcond;
  always_comb begin
    state_nx = S_FETCH;
    case (state)
      S_FETCH: state_nx = S_DECODE;
      S_DECODE:
        case (Op)
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_RTYPE:     state_nx = S_RTYPEEX;
          OP_BEQ:       state_nx = S_BEQEX;
`ifdef MC_BNE_EN
          OP_BNE:       state_nx = S_BNEEX;
`endif
          OP_ADDI:      state_nx = S_ADDIEX;
          OP_J:         state_nx = S_JEX;
          default:      state_nx = S_ILLEGAL;
        endcase
      S_MEMADR:  state_nx = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_nx = S_MEMWB;
      S_RTYPEEX: state_nx = S_RTYPEWB;
      S_ADDIEX:  state_nx = S_ADDIWB;
      S_ILLEGAL: state_nx = S_ILLEGAL;
      default: ;
    endcase
  end
  always_ff @(posedge CLK)
    state <= RST ? S_FETCH : state_nx;
  mc_ctrl_outdec u_outdec (.state(state), .ctrl(c));
`ifdef MC_BNE_EN
  assign bcond = (state == S_BNEEX) ? ~Zero : Zero;
`else
  assign bcond = Zero;
`endif
  // Write enables are gated by RST so a mid-instruction reset commits nothing
  assign IorD      = c.iord;
  assign MemWrite  = c.mem_write & ~RST;
  assign IRWrite   = c.ir_write & ~RST;
  assign RegDst    = c.reg_dst;
  assign MemtoReg  = c.mem_to_reg;
  assign RegWrite  = c.reg_write & ~RST;
  assign ALUSrcA   = c.alu_src_a;
  assign ALUSrcB   = c.alu_src_b;
  assign ALUOp     = c.alu_op;
  assign PCSrc     = c.pc_src;
  assign PCEn      = ~RST & (c.pc_write | (c.branch & bcond));
  assign InstrDone = c.instr_done & ~RST;
  assign Trap      = c.trap;
endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb_mc_main_ctrl: randomized instruction-level checks of mc_main_ctrl against a per-cycle reference model
module tb_mc_main_ctrl;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [15:0] MASK = 16'h6406;
  localparam int ILL_LEN = 22;
`ifdef MC_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif
  logic CLK = 1'b0, RST = 1'b1, Zero = 1'b0;
  logic [5:0] Op = '0;
  logic IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, InstrDone, Trap;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [15:0] obs;
  int errors = 0, checks = 0;

  mc_main_ctrl dut (
    .CLK(CLK), .RST(RST), .Op(Op), .Zero(Zero), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
    .InstrDone(InstrDone), .Trap(Trap)
  );

  always #5 CLK = ~CLK;
  assign obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
                ALUOp, PCSrc, PCEn, InstrDone, Trap};

  function automatic int latency(input logic [5:0] op);
    case (op)
      LW: return 5;
      SW, RT, ADDI: return 4;
      BEQ, JMP: return 3;
      BNE: return BNE_EN ? 3 : ILL_LEN;
      default: return ILL_LEN;
    endcase
  endfunction

  // Expected outputs in cycle k of an instruction (k=0 is fetch), from the instruction's phase list
  function automatic logic [15:0] expect_word(input logic [5:0] op, input int k, input logic z);
    logic iord, mw, ir, rd, m2r, rw, sa, pe, dn, tr;
    logic [1:0] sb, ao, ps;
    {iord, mw, ir, rd, m2r, rw, sa, pe, dn, tr} = '0;
    {sb, ao, ps} = '0;
    if (k == 0) begin
      ir = 1'b1; sb = 2'b01; pe = 1'b1;
    end else if (k == 1) begin
      sb = 2'b11;
    end else begin
      case (op)
        LW:
          if (k == 2) begin sa = 1'b1; sb = 2'b10; end
          else if (k == 3) iord = 1'b1;
          else begin m2r = 1'b1; rw = 1'b1; dn = 1'b1; end
        SW:
          if (k == 2) begin sa = 1'b1; sb = 2'b10; end
          else begin iord = 1'b1; mw = 1'b1; dn = 1'b1; end
        RT:
          if (k == 2) begin sa = 1'b1; ao = 2'b10; end
          else begin rd = 1'b1; rw = 1'b1; dn = 1'b1; end
        ADDI:
          if (k == 2) begin sa = 1'b1; sb = 2'b10; end
          else begin rw = 1'b1; dn = 1'b1; end
        BEQ: begin sa = 1'b1; ao = 2'b01; ps = 2'b01; pe = z; dn = 1'b1; end
        JMP: begin ps = 2'b10; pe = 1'b1; dn = 1'b1; end
        BNE:
          if (BNE_EN) begin sa = 1'b1; ao = 2'b01; ps = 2'b01; pe = ~z; dn = 1'b1; end
          else tr = 1'b1;
        default: tr = 1'b1;
      endcase
    end
    return {iord, mw, ir, rd, m2r, rw, sa, sb, ao, ps, pe, dn, tr};
  endfunction

  // Entered just after a negedge with the DUT in FETCH; leaves it the same way.
  // zf < 0 randomizes Zero; rst_k >= 0 asserts RST in that cycle and aborts the instruction.
  task automatic run_instr(input logic [5:0] op, input int rst_k, input int zf);
    int n, done;
    logic [15:0] e;
    n = latency(op);
    done = 0;
    for (int k = 0; k < n; k++) begin
      Op = (k == 1 || k == 2) ? op : 6'($urandom);
      Zero = (zf < 0) ? 1'($urandom) : 1'(zf);
      if (k == rst_k) RST = 1'b1;
      #1;
      e = expect_word(op, k, Zero);
      if (RST) e = e & ~MASK;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL cycle op=%b k=%0d got=%b want=%b", op, k, obs, e);
      end
      done += int'(InstrDone);
      @(negedge CLK);
      if (RST) break;
    end
    checks++;
    if (done != ((rst_k >= 0 || n == ILL_LEN) ? 0 : 1)) begin
      errors++;
      $display("FAIL instr_done_count op=%b got=%0d", op, done);
    end
    if (n == ILL_LEN) begin
      RST = 1'b1;
      #1;
      checks++;
      if (obs !== 16'h0001) begin
        errors++;
        $display("FAIL illegal_in_reset op=%b got=%b want=%b", op, obs, 16'h0001);
      end
      @(negedge CLK);
    end
    if (RST) begin
      #1;
      checks++;
      if (obs !== (expect_word(op, 0, 1'b0) & ~MASK)) begin
        errors++;
        $display("FAIL fetch_after_reset op=%b got=%b want=%b", op, obs,
                 expect_word(op, 0, 1'b0) & ~MASK);
      end
      RST = 1'b0;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if (obs !== 16'h0080) begin
      errors++;
      $display("FAIL reset_state got=%b want=%b", obs, 16'h0080);
    end
    RST = 1'b0;
  endtask

  task automatic test_lw();
    run_instr(LW, -1, -1);
  endtask

  task automatic test_beq();
    run_instr(BEQ, -1, 1);
    run_instr(BEQ, -1, 0);
  endtask

  task automatic test_j_sw();
    run_instr(JMP, -1, -1);
    run_instr(SW, -1, -1);
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, -1, -1);
    run_instr(6'b000001, -1, -1);
    run_instr(ADDI, -1, -1);
  endtask

  task automatic test_reset_mid();
    run_instr(LW, 4, -1);
    run_instr(RT, -1, -1);
    run_instr(SW, 2, -1);
    run_instr(ADDI, -1, -1);
  endtask

  task automatic test_bne();
    run_instr(BNE, -1, 0);
    run_instr(BNE, -1, 1);
    run_instr(BEQ, -1, -1);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [6] = '{LW, SW, RT, BEQ, ADDI, JMP};
    for (int i = 0; i < 40; i++) run_instr(ops[$urandom_range(5)], -1, -1);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_beq();
    test_j_sw();
    test_illegal();
    test_reset_mid();
    test_bne();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
